// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared pipeline-control definitions for the RV32I core:
//   - optype encodings, identical to the decoder's hazard_optype output
//   - ID operand forward-select encodings
//   - shadow pipeline entry struct used by the hazard unit
//   - register match helper used for every hazard/forward decision
package rv_ctrl_pkg;

   localparam int REG_IDX_BITS = 5;

   localparam logic [1:0] OPT_NONE  = 2'd0;
   localparam logic [1:0] OPT_ALU   = 2'd1;
   localparam logic [1:0] OPT_LOAD  = 2'd2;   // CSR ops are classed as loads
   localparam logic [1:0] OPT_STORE = 2'd3;

   localparam logic [1:0] FWD_RF      = 2'd0;
   localparam logic [1:0] FWD_EX_ALU  = 2'd1;
   localparam logic [1:0] FWD_MEM_ALU = 2'd2;
   localparam logic [1:0] FWD_MEM_LD  = 2'd3;

   typedef struct packed {
      logic [1:0]              optype;
      logic [REG_IDX_BITS-1:0] rd;
      logic                    store_fwd;   // store data must come from the WB load
   } shadow_entry_t;

   localparam shadow_entry_t SHADOW_BUBBLE = '{
      optype:    OPT_NONE,
      rd:        {REG_IDX_BITS{1'b0}},
      store_fwd: 1'b0
   };

   // A source operand depends on an entry when it is used, is not x0,
   // names the entry's destination, and the entry is of the given kind.
   function automatic logic reg_match(
      input logic [REG_IDX_BITS-1:0] rs,
      input logic                    src_used,
      input shadow_entry_t           entry,
      input logic [1:0]              opt
   );
      logic hit;
      hit = src_used && (rs != {REG_IDX_BITS{1'b0}}) &&
            (entry.rd == rs) && (entry.optype == opt);
      return hit;
   endfunction

endpackage

// File: rtl/hazard_track_stage.sv
// hazard_track_stage
// One shadow pipeline register of the hazard unit.
//   clk      core clock
//   rst_n    asynchronous active-low reset, resets to a bubble
//   advance  capture d on the next rising edge
//   bubble   capture a bubble instead (has priority over advance)
//   d        incoming entry from the previous stage
//   q        current stage occupant
module hazard_track_stage
   import rv_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          advance,
   input  logic          bubble,
   input  shadow_entry_t d,
   output shadow_entry_t q
);

   // Stage occupant register with bubble insertion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SHADOW_BUBBLE;
      end else if (bubble) begin
         q <= SHADOW_BUBBLE;
      end else if (advance) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit
// Stall / flush / forwarding controller for the 5-stage RV32I pipeline.
// Tracks shadow copies of the EX and MEM occupants and, from the ID
// instruction's decode, produces:
//   pc_stall, ifid_stall, idex_bubble   load-use stall (one bubble)
//   ifid_flush, idex_flush, exmem_flush branch / trap squashes
//   fwd_rs1_sel, fwd_rs2_sel            ID operand forwarding selects
//   mem_fwd_rs2                         store in MEM takes WB load data
// Inputs: decoder use flags, optype, register indices, branch_id and
// trap_flush. Everything except mem_fwd_rs2 is combinational.
module hazard_detect_unit
   import rv_ctrl_pkg::*;
#(
   parameter int NUM_REG_BITS = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rs1use_id,
   input  logic                    rs2use_id,
   input  logic [1:0]              optype_id,
   input  logic [NUM_REG_BITS-1:0] rs1_id,
   input  logic [NUM_REG_BITS-1:0] rs2_id,
   input  logic [NUM_REG_BITS-1:0] rd_id,
   input  logic                    branch_id,
   input  logic                    trap_flush,
   output logic                    pc_stall,
   output logic                    ifid_stall,
   output logic                    idex_bubble,
   output logic                    ifid_flush,
   output logic                    idex_flush,
   output logic                    exmem_flush,
   output logic [1:0]              fwd_rs1_sel,
   output logic [1:0]              fwd_rs2_sel,
   output logic                    mem_fwd_rs2
);

   shadow_entry_t id_entry_s;
   shadow_entry_t ex_entry_r;
   shadow_entry_t mem_entry_r;

   logic ex_ld_rs1_s;
   logic ex_ld_rs2_s;
   logic load_use_s;
   logic stall_s;
   logic store_fwd_s;
   logic ex_bubble_s;

   // Select the youngest producer of an operand; EX beats MEM.
   // A LOAD still in EX either stalls or (store data) is handled in MEM,
   // so it yields the register file here.
   function automatic logic [1:0] fwd_pick(
      input logic [REG_IDX_BITS-1:0] rs,
      input logic                    src_used,
      input shadow_entry_t           ex_e,
      input shadow_entry_t           mem_e
   );
      logic [1:0] sel;
      if (reg_match(rs, src_used, ex_e, OPT_ALU)) begin
         sel = FWD_EX_ALU;
      end else if (reg_match(rs, src_used, ex_e, OPT_LOAD)) begin
         sel = FWD_RF;
      end else if (reg_match(rs, src_used, mem_e, OPT_ALU)) begin
         sel = FWD_MEM_ALU;
      end else if (reg_match(rs, src_used, mem_e, OPT_LOAD)) begin
         sel = FWD_MEM_LD;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

   // Load-use detection and the ID entry handed to the EX shadow
   always_comb begin
      ex_ld_rs1_s = reg_match(rs1_id, rs1use_id, ex_entry_r, OPT_LOAD);
      ex_ld_rs2_s = reg_match(rs2_id, rs2use_id, ex_entry_r, OPT_LOAD);
      // Store data of a store behind a load is patched in MEM, not stalled on
      load_use_s  = ex_ld_rs1_s || (ex_ld_rs2_s && (optype_id != OPT_STORE));
      stall_s     = load_use_s && !trap_flush;
      store_fwd_s = (optype_id == OPT_STORE) && ex_ld_rs2_s && !ex_ld_rs1_s;
      ex_bubble_s = stall_s || trap_flush;

      id_entry_s.optype    = optype_id;
      id_entry_s.rd        = rd_id;
      id_entry_s.store_fwd = store_fwd_s;
   end

   hazard_track_stage u_ex_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (1'b1),
      .bubble  (ex_bubble_s),
      .d       (id_entry_s),
      .q       (ex_entry_r)
   );

   hazard_track_stage u_mem_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (1'b1),
      .bubble  (trap_flush),
      .d       (ex_entry_r),
      .q       (mem_entry_r)
   );

   // Stall, flush and forward-select outputs; forced quiet during reset
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      fwd_rs1_sel = FWD_RF;
      fwd_rs2_sel = FWD_RF;
      if (rst_n) begin
         pc_stall    = stall_s;
         ifid_stall  = stall_s;
         idex_bubble = stall_s;
         // A stalled branch re-resolves next cycle; a trap squashes regardless
         ifid_flush  = trap_flush || (branch_id && !stall_s);
         idex_flush  = trap_flush;
         exmem_flush = trap_flush;
         if (stall_s) begin
            fwd_rs1_sel = FWD_RF;
            fwd_rs2_sel = FWD_RF;
         end else begin
            fwd_rs1_sel = fwd_pick(rs1_id, rs1use_id, ex_entry_r, mem_entry_r);
            fwd_rs2_sel = fwd_pick(rs2_id, rs2use_id, ex_entry_r, mem_entry_r);
         end
      end else begin
         pc_stall    = 1'b0;
         ifid_stall  = 1'b0;
         idex_bubble = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         exmem_flush = 1'b0;
         fwd_rs1_sel = FWD_RF;
         fwd_rs2_sel = FWD_RF;
      end
   end

   assign mem_fwd_rs2 = mem_entry_r.store_fwd;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit
// Directed-vector bench for hazard_detect_unit. Each vector drives one ID
// instruction and compares the packed outputs
//   {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
//    exmem_flush, fwd_rs1_sel, fwd_rs2_sel, mem_fwd_rs2}
// against a hand-computed value.
module tb_hazard_detect_unit;

   logic       clk;
   logic       rst_n;
   logic       rs1use_id;
   logic       rs2use_id;
   logic [1:0] optype_id;
   logic [4:0] rs1_id;
   logic [4:0] rs2_id;
   logic [4:0] rd_id;
   logic       branch_id;
   logic       trap_flush;
   logic       pc_stall;
   logic       ifid_stall;
   logic       idex_bubble;
   logic       ifid_flush;
   logic       idex_flush;
   logic       exmem_flush;
   logic [1:0] fwd_rs1_sel;
   logic [1:0] fwd_rs2_sel;
   logic       mem_fwd_rs2;

   int total_cnt;
   int bad_cnt;

   hazard_detect_unit #(.NUM_REG_BITS(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rs1use_id   (rs1use_id),
      .rs2use_id   (rs2use_id),
      .optype_id   (optype_id),
      .rs1_id      (rs1_id),
      .rs2_id      (rs2_id),
      .rd_id       (rd_id),
      .branch_id   (branch_id),
      .trap_flush  (trap_flush),
      .pc_stall    (pc_stall),
      .ifid_stall  (ifid_stall),
      .idex_bubble (idex_bubble),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_flush (exmem_flush),
      .fwd_rs1_sel (fwd_rs1_sel),
      .fwd_rs2_sel (fwd_rs2_sel),
      .mem_fwd_rs2 (mem_fwd_rs2)
   );

   // Core clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [10:0] got, input logic [10:0] exp);
      total_cnt = total_cnt + 1;
      if (got !== exp) begin
         bad_cnt = bad_cnt + 1;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Settle, then compare the packed outputs
   task automatic expect_outs(input string tag, input logic [10:0] exp);
      #1;
      check_val(tag, {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
                      exmem_flush, fwd_rs1_sel, fwd_rs2_sel, mem_fwd_rs2}, exp);
   endtask

   // Present one ID instruction
   task automatic drive(input logic u1, input logic u2, input logic [1:0] opt,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic br, input logic tr);
      rs1use_id  = u1;
      rs2use_id  = u2;
      optype_id  = opt;
      rs1_id     = r1;
      rs2_id     = r2;
      rd_id      = rd;
      branch_id  = br;
      trap_flush = tr;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Two empty cycles empty both shadow stages
   task automatic drain();
      nop();
      tick();
      tick();
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      rst_n     = 1'b0;
      nop();
      branch_id = 1'b1;
      trap_flush = 1'b1;
      #2;
      expect_outs("reset_quiet", 11'b000_000_00_00_0);
      nop();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      expect_outs("post_reset", 11'b000_000_00_00_0);

      // addi x5,x0,1 ; add x6,x5,x5 ; add x10,x5,x6
      drive(1'b1, 1'b0, 2'd1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
      expect_outs("addi_x5", 11'b000_000_00_00_0);
      tick();
      drive(1'b1, 1'b1, 2'd1, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0);
      expect_outs("ex_alu_fwd", 11'b000_000_01_01_0);
      tick();
      drive(1'b1, 1'b1, 2'd1, 5'd5, 5'd6, 5'd10, 1'b0, 1'b0);
      expect_outs("mem_alu_fwd", 11'b000_000_10_01_0);
      drain();

      // two writers of x5: EX copy wins
      drive(1'b1, 1'b0, 2'd1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 2'd1, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 2'd1, 5'd5, 5'd0, 5'd13, 1'b0, 1'b0);
      expect_outs("ex_over_mem", 11'b000_000_01_00_0);
      drain();

      // lw x7,0(x1) ; beq x7,x0
      drive(1'b1, 1'b0, 2'd2, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 2'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0);
      expect_outs("load_use_stall", 11'b111_000_00_00_0);
      tick();
      expect_outs("load_use_mem_ld", 11'b000_100_11_00_0);
      drain();

      // lw x8,0(x1) ; sw x8,4(x2)
      drive(1'b1, 1'b0, 2'd2, 5'd1, 5'd0, 5'd8, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 2'd3, 5'd2, 5'd8, 5'd4, 1'b0, 1'b0);
      expect_outs("st_after_ld_id", 11'b000_000_00_00_0);
      tick();
      nop();
      expect_outs("st_in_ex", 11'b000_000_00_00_0);
      tick();
      expect_outs("st_in_mem", 11'b000_000_00_00_1);
      tick();
      expect_outs("st_left_mem", 11'b000_000_00_00_0);
      drain();

      // lw x8 ; sw x8,0(x8): base register stalls, data then from MEM load
      drive(1'b1, 1'b0, 2'd2, 5'd1, 5'd0, 5'd8, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 2'd3, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
      expect_outs("st_base_stall", 11'b111_000_00_00_0);
      tick();
      expect_outs("st_base_mem_ld", 11'b000_000_11_11_0);
      tick();
      nop();
      tick();
      expect_outs("st_base_no_mfwd", 11'b000_000_00_00_0);
      drain();

      // addi x0,x0,5 ; add x9,x0,x0
      drive(1'b1, 1'b0, 2'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 2'd1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
      expect_outs("x0_no_fwd", 11'b000_000_00_00_0);
      drain();

      // taken jal x1
      drive(1'b0, 1'b0, 2'd1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      expect_outs("jal_flush", 11'b000_100_00_00_0);
      tick();
      nop();
      expect_outs("jal_flush_once", 11'b000_000_00_00_0);
      drain();

      // trap during a load-use stall
      drive(1'b1, 1'b0, 2'd2, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 2'd1, 5'd7, 5'd0, 5'd11, 1'b1, 1'b0);
      expect_outs("pre_trap_stall", 11'b111_000_00_00_0);
      trap_flush = 1'b1;
      expect_outs("trap_override", 11'b000_111_00_00_0);
      tick();
      drive(1'b1, 1'b0, 2'd1, 5'd7, 5'd0, 5'd11, 1'b0, 1'b0);
      expect_outs("trap_cleared", 11'b000_000_00_00_0);
      drain();

      // reset dropped while a load sits in EX
      drive(1'b1, 1'b0, 2'd2, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 2'd1, 5'd7, 5'd0, 5'd12, 1'b1, 1'b0);
      expect_outs("pre_rst_stall", 11'b111_000_00_00_0);
      rst_n = 1'b0;
      expect_outs("rst_mid_stall", 11'b000_000_00_00_0);
      tick();
      rst_n = 1'b1;
      branch_id = 1'b0;
      tick();
      expect_outs("after_rst_dep", 11'b000_000_00_00_0);
      drain();

      // back-to-back loads to x7, then a consumer: one stall only
      drive(1'b1, 1'b0, 2'd2, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 2'd2, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
      expect_outs("ld_ld_no_stall", 11'b000_000_00_00_0);
      tick();
      drive(1'b1, 1'b0, 2'd1, 5'd7, 5'd0, 5'd12, 1'b0, 1'b0);
      expect_outs("ld_ld_stall", 11'b111_000_00_00_0);
      tick();
      expect_outs("ld_ld_once", 11'b000_000_11_00_0);
      drain();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
